// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
//   OP_*  : operation select carried on the op port
//   ST_*  : control FSM state encodings
package muldiv_pkg;

  localparam logic [1:0] OP_MULT   = 2'b00;
  localparam logic [1:0] OP_MULTU  = 2'b01;
  localparam logic [1:0] OP_DIV    = 2'b10;
  localparam logic [1:0] OP_DIVU   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREP   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation.
//   neg_i : 1 = output the negated value, 0 = pass through
//   val_i : input value (W bits)
//   val_o : val_i or -val_i (W bits)
module muldiv_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide unit owning the HI/LO result registers.
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   start, op         : request (sampled in IDLE) and operation select
//   abort             : synchronous cancel of the operation in flight
//   a, b              : operands, captured when start is accepted
//   busy, done        : busy outside IDLE; done pulses once per completed operation
//   hi, lo            : product high/low or remainder/quotient
//   div_by_zero       : divide with b==0 (valid with done)
//   mult_ovf          : product does not fit in WIDTH bits (valid with done)
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             mult_ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic               signed_op, is_div;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, step_next;
  logic [WIDTH:0]     mul_sum, div_r, div_diff;

  assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);

  muldiv_negate #(.W(WIDTH)) u_mag_a (
    .neg_i(signed_op & a_q[WIDTH-1]), .val_i(a_q), .val_o(mag_a));
  muldiv_negate #(.W(WIDTH)) u_mag_b (
    .neg_i(signed_op & b_q[WIDTH-1]), .val_i(b_q), .val_o(mag_b));
  muldiv_negate #(.W(2*WIDTH)) u_prod_fix (
    .neg_i(neg_res_q), .val_i(acc_q), .val_o(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_quo_fix (
    .neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_fix));
  muldiv_negate #(.W(WIDTH)) u_rem_fix (
    .neg_i(neg_rem_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .val_o(rem_fix));

  // Multiply: multiplier sits in the low half and shifts out LSB-first while
  // partial sums accumulate into the high half (carry lands in the MSB).
  // Divide: remainder in the high half, dividend/quotient in the low half;
  // shift left, trial-subtract, keep the difference when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_r    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_r - {1'b0, opnd_q};
    if (!is_div)
      step_next = {mul_sum, acc_q[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step_next = {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      step_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        neg_res_d = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = signed_op & a_q[WIDTH-1];
        acc_d     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        opnd_d    = is_div ? mag_b : mag_a;
        cnt_d     = '0;
        if (is_div && (b_q == '0)) begin
          dbz_pend_d = 1'b1;
          state_d    = ST_FINISH;
        end else begin
          dbz_pend_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (dbz_pend_q) begin
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else if (is_div) begin
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end else begin
          {hi_d, lo_d} = prod_fix;
          dbz_d = 1'b0;
          if (op_q == OP_MULTU)
            ovf_d = |prod_fix[2*WIDTH-1:WIDTH];
          else
            ovf_d = prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything above, including a same-cycle FINISH write.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign mult_ovf    = ovf_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        abort = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero, mult_ovf;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Last successfully written HI/LO as seen by the reference model.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .mult_ovf(mult_ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural operation.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo,
                       output logic eovf, output logic edbz, output int elat);
    longint sx, sy, p, q, r;
    longint unsigned up;
    ehi = m_hi; elo = m_lo; eovf = 1'b0; edbz = 1'b0; elat = 34;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = sx * sy;
        ehi = p[63:32]; elo = p[31:0];
        eovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        ehi = up[63:32]; elo = up[31:0];
        eovf = up[63:32] != 0;
      end
      default: begin
        if (y == 0) begin
          edbz = 1'b1; elat = 2;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          ehi = r[31:0]; elo = q[31:0];
        end else begin
          ehi = x % y; elo = x / y;
        end
      end
    endcase
  endtask

  // Issues one request and returns the number of edges after acceptance at
  // which done was seen (-1 if it never came). Operand inputs are scrambled
  // after acceptance so that capture is exercised.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({busy, done, div_by_zero, mult_ovf} !== 4'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b ovf=%b hi=%h lo=%h, want all zero",
               busy, done, div_by_zero, mult_ovf, hi, lo);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op  [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] t_a   [6] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000};
    logic [31:0] t_b   [6] = '{32'hFFFFFFFF, 32'd6, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_hi  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'h0};
    logic [31:0] t_lo  [6] = '{32'h00000001, 32'hFFFFFFD6, 32'hFFFFFFFD, 32'd14, 32'd14, 32'h80000000};
    logic        t_ovf [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        t_dbz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          t_lat [6] = '{34, 34, 34, 34, 2, 34};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat);
      checks++;
      if (lat !== t_lat[i]) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, t_lat[i]);
      end
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h want hi=%h lo=%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
      checks++;
      if (mult_ovf !== t_ovf[i] || div_by_zero !== t_dbz[i]) begin
        errors++;
        $display("FAIL directed[%0d] flags: ovf=%b dbz=%b want ovf=%b dbz=%b",
                 i, mult_ovf, div_by_zero, t_ovf[i], t_dbz[i]);
      end
      m_hi = t_hi[i]; m_lo = t_lo[i];
    end
  endtask

  task automatic test_start_ignored;
    logic [31:0] ehi, elo;
    logic eovf, edbz;
    int elat, lat, extra;
    logic [31:0] x, y;
    x = $urandom; y = $urandom_range(1000, 1);
    model(2'b11, x, y, ehi, elo, eovf, edbz, elat);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    lat = -1;
    for (int n = 7; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 34 || hi !== ehi || lo !== elo) begin
      errors++;
      $display("FAIL start_ignored: lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h",
               lat, hi, lo, ehi, elo);
    end
    m_hi = ehi; m_lo = elo;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) extra++; end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL start_ignored_queue: %0d busy/done cycles seen, want 0", extra);
    end
  endtask

  task automatic test_abort;
    int seen;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: busy=%b want 1", busy);
    end
    repeat (11) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_exit: busy=%b done=%b want 0 0", busy, done);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++;
    if (seen !== 0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL abort_hold: done_count=%0d hi=%h lo=%h want 0 hi=%h lo=%h",
               seen, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               busy, done, hi, lo);
    end
    #2; reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_random;
    logic [31:0] ehi, elo, x, y;
    logic [31:0] edge_vals [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1};
    logic [1:0] o;
    logic eovf, edbz;
    int elat, lat;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(3, 0));
      case ($urandom_range(3, 0))
        0: begin x = $urandom_range(20, 0); y = $urandom_range(5, 0); end
        1: begin x = edge_vals[$urandom_range(3, 0)]; y = edge_vals[$urandom_range(3, 0)]; end
        2: begin x = $urandom; y = $urandom_range(65535, 0); end
        default: begin x = $urandom; y = $urandom; end
      endcase
      model(o, x, y, ehi, elo, eovf, edbz, elat);
      run_op(o, x, y, lat);
      checks++;
      if (lat !== elat || hi !== ehi || lo !== elo || mult_ovf !== eovf || div_by_zero !== edbz) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h ovf=%b dbz=%b want lat=%0d hi=%h lo=%h ovf=%b dbz=%b",
                 i, o, x, y, lat, hi, lo, mult_ovf, div_by_zero, elat, ehi, elo, eovf, edbz);
      end
      m_hi = ehi; m_lo = elo;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
